// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Collects rising edges on N_CH asynchronous level inputs into per-channel
// pending flags and hands them one at a time to a single consumer over a
// valid/ready handshake, using a round-robin search that starts at rr_ptr.
//
// Build option: define EDGE_ARB_OVERRUN_EN to enable the sticky per-channel
// overrun flags, which record an edge that arrived while that channel's
// event was still pending. Without it, overrun is tied to 0 and ovr_clr is
// ignored.
//
// Arbiter states:
//   state   | meaning
//   S_IDLE  | nothing offered; pick the next pending channel, if any
//   S_OFFER | evt_ch is offered with evt_valid=1 until the consumer takes it
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDX_W-1:0]  evt_ch,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   overrun,
  input  logic              ovr_clr
);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [N_CH-1:0]   f1;
  logic [N_CH-1:0]   f2;
  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   clr_vec;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_ptr_nxt;
  logic              hs;
  logic              grant_found;
  logic [IDX_W-1:0]  grant_ch;
  logic [IDX_W-1:0]  cand_idx;
  int                cand;

  // Two-flop edge detector; resetting to 1 hides inputs already high at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1 <= '1;
      f2 <= '1;
    end else begin
      f1 <= in;
      f2 <= f1;
    end
  end

  assign rise = f1 & ~f2;

  // One-hot clear of the channel whose event is accepted this cycle.
  always_comb begin
    clr_vec = '0;
    if (hs) begin
      clr_vec[evt_ch] = 1'b1;
    end
  end

  // Pending flags: a new edge wins over a simultaneous handshake clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | rise;
    end
  end

`ifdef EDGE_ARB_OVERRUN_EN
  // Sticky overrun: an edge merged into a still-pending, not-being-cleared flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= '0;
    end else begin
      overrun <= (overrun & ~{N_CH{ovr_clr}}) | (rise & pending & ~clr_vec);
    end
  end
`else
  logic ovr_clr_unused;
  assign ovr_clr_unused = ovr_clr;
  assign overrun        = '0;
`endif

  // Round-robin search: first pending channel at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 0; off < N_CH; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!grant_found && pending[cand_idx]) begin
        grant_found = 1'b1;
        grant_ch    = cand_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: an offer is held until the consumer accepts it.
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (grant_found) begin
        state_d = S_OFFER;
      end
    end else begin
      if (evt_ready) begin
        state_d = S_IDLE;
      end
    end
  end

  // FSM outputs: valid while offering; a handshake is valid & ready.
  always_comb begin
    evt_valid = (state_q == S_OFFER);
    hs        = evt_valid & evt_ready;
  end

  assign rr_ptr_nxt = (evt_ch == IDX_W'(N_CH - 1)) ? '0 : evt_ch + 1'b1;

  // Offered channel is captured on grant; rr_ptr advances past it on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_ch <= '0;
      rr_ptr <= '0;
    end else begin
      if (state_q == S_IDLE && grant_found) begin
        evt_ch <= grant_ch;
      end
      if (hs) begin
        rr_ptr <= rr_ptr_nxt;
      end
    end
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel rising-edge event collector and round-robin scheduler. Each of `N_CH` asynchronous level inputs passes through a two-flop edge detector; each detected rising edge latches a per-channel pending flag. A round-robin arbiter presents pending events one at a time to a single downstream consumer over a valid/ready handshake. It sits between external status or interrupt lines and the control logic that services them.

## Interface

- `N_CH`, 4: number of input channels, 2..16.
- `IDX_W`, 2: channel index width, 2^IDX_W >= N_CH.

- `clk`, input, 1: clock, all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in`, input, N_CH: raw level inputs, one per channel.
- `evt_valid`, output, 1: an event is offered.
- `evt_ready`, input, 1: the consumer accepts the offered event.
- `evt_ch`, output, IDX_W: channel of the offered event.
- `pending`, output, N_CH: per-channel pending flags.
- `overrun`, output, N_CH: sticky per-channel lost-event flags (see Configuration).
- `ovr_clr`, input, 1: clears all `overrun` bits.

## Operation

- **Edge detect, per channel i:**
  - `F1[i] <= in[i]`; `F2[i] <= F1[i]`.
  - `rise[i] = F1[i] & ~F2[i]`.
  - Only rising edges are detected.
- **Pending, per channel:**
  - Set on a clock edge where `rise[i]`=1.
  - Cleared on a clock edge where a handshake completes (`evt_valid & evt_ready`) with `evt_ch`=i.
  - If set and clear coincide, set wins: pending stays 1 and no overrun is flagged.
- **Arbiter FSM:**
  - IDLE:
    - `evt_valid`=0.
    - If `pending`≠0, grant the first pending channel found searching upward from `rr_ptr`, wrapping modulo N_CH.
    - Load `evt_ch`, go to OFFER.
  - OFFER:
    - `evt_valid`=1.
    - `evt_ch` and `evt_valid` stay stable until `evt_ready`=1.
    - On handshake: `rr_ptr <= (evt_ch+1) mod N_CH`, go to IDLE.
  - An offered event is never withdrawn.
  - `pending[evt_ch]` remains 1 while offered.
- **Reset (asserted at any time, including mid-handshake), all immediately:**
  - `F1`, `F2` = all 1s.
  - `pending`=0, `overrun`=0, `evt_valid`=0, `evt_ch`=0, `rr_ptr`=0.
  - FSM to IDLE.
  - Because the detector flops reset to 1, an input already high at reset release produces no event.

## Timing

- **Latency:**
  - `in[i]` rises before clock edge k, so `F1[i]`=1 after k.
  - `pending[i]`=1 after k+1.
  - `evt_valid`=1 after k+2, when the FSM is in IDLE with no other winner.
- **Throughput:** at most one event per 2 cycles, because the FSM passes through a mandatory IDLE cycle after each handshake.
- **Minimum input pulse:** an input must be high for at least one full clock period for its edge to be detected.
- **Handshake:** a transfer occurs on any clock edge with `evt_valid & evt_ready`=1. `evt_ready` is ignored while `evt_valid`=0.
- **Simultaneous pending:** the lowest channel index at or above `rr_ptr` wins; the search wraps from N_CH-1 to 0.

## Configuration

- Macro: `EDGE_ARB_OVERRUN_EN`.
- **Defined:**
  - `overrun[i]` sets on a clock edge where `rise[i]`=1 while `pending[i]` is already 1 and is not being cleared that cycle.
  - `ovr_clr` clears all bits.
  - If set and clear coincide, set wins.
  - The second edge is merged into the existing pending flag (one event delivered).
- **Undefined:**
  - `overrun` is constant 0 and `ovr_clr` is ignored.
  - Edge merging behaviour is unchanged.

## Test plan

- **Reset with inputs high:** release reset with `in`=4'b1111 held → no `pending` bit and no `evt_valid` ever.
- **Single-edge latency:** 0→1 on `in[2]` before edge k, `evt_ready`=1 → `evt_valid`=1 with `evt_ch`=2 after edge k+2, `pending[2]`=0 after k+3.
- **Simultaneous edges:** rise on all 4 channels in the same cycle, `evt_ready`=1 → grants in order 0,1,2,3, one every 2 cycles. A further rise on ch0 and ch3 then grants ch0 first (`rr_ptr` has wrapped to 0).
- **Backpressure and overrun (macro defined):** with `evt_ready`=0, rise on ch1 twice → `evt_ch`=1 held stable and `overrun[1]`=1. After raising `evt_ready`, exactly one ch1 event is delivered. Pulsing `ovr_clr` → `overrun`=0. With the macro undefined, `overrun` stays 0.
- **Set/clear collision:** rise on ch0 in the same cycle as the ch0 handshake → `pending[0]` stays 1, a second ch0 event is offered, `overrun[0]`=0.
- **Reset mid-offer:** assert `rst_n`=0 while `evt_valid`=1 → `evt_valid`, `pending` and `overrun` all 0 immediately. After release, no event is delivered until a new rising edge.
